// File: rtl/alu_defs.sv
// Shared ALU opcode encodings and datapath widths for the ID/EX issue stage.
package alu_defs;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_NOT  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_AND  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0101;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_MOVE = 4'b1001;
endpackage

// File: rtl/id_ex_issue_fwd_mux.sv
// Operand forwarding mux: picks the youngest in-flight result for register r.
module fwd_mux
    import alu_defs::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] r,
    input  logic [DW-1:0] v,
    input  logic          ex_mem_reg_write,
    input  logic [AW-1:0] ex_mem_rd,
    input  logic [DW-1:0] ex_mem_result,
    input  logic          mem_wb_reg_write,
    input  logic [AW-1:0] mem_wb_rd,
    input  logic [DW-1:0] mem_wb_result,
    output logic [DW-1:0] q
);
    // r0 is hardwired zero, so writes to it never forward.
    always_comb begin
        q = v;
        if (r != '0) begin
            if (ex_mem_reg_write && ex_mem_rd == r)
                q = ex_mem_result;
            else if (mem_wb_reg_write && mem_wb_rd == r)
                q = mem_wb_result;
        end
    end
endmodule

// File: rtl/id_ex_issue.sv
// ID/EX pipeline register with operand forwarding, load-use stall and bubble insertion.
module id_ex_issue
    import alu_defs::*;
#(
    parameter int DW  = DATA_W,
    parameter int AW  = REG_AW,
    parameter int OPW = OP_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [OPW-1:0] id_aluop,
    input  logic [4:0]     id_shamt,
    input  logic [AW-1:0]  id_rs,
    input  logic [AW-1:0]  id_rt,
    input  logic [AW-1:0]  id_rd,
    input  logic [DW-1:0]  id_rs_data,
    input  logic [DW-1:0]  id_rt_data,
    input  logic [DW-1:0]  id_imm,
    input  logic           id_use_imm,
    input  logic           id_uses_rt,
    input  logic           id_reg_write,
    input  logic           id_mem_read,
    input  logic           id_mem_write,
    input  logic           hold,
    input  logic           flush,
    input  logic           ex_mem_reg_write,
    input  logic [AW-1:0]  ex_mem_rd,
    input  logic [DW-1:0]  ex_mem_result,
    input  logic           mem_wb_reg_write,
    input  logic [AW-1:0]  mem_wb_rd,
    input  logic [DW-1:0]  mem_wb_result,
    output logic           stall,
    output logic           ex_valid,
    output logic [OPW-1:0] aluop_selector,
    output logic [4:0]     shamt,
    output logic [DW-1:0]  alu_in1,
    output logic [DW-1:0]  alu_in2,
    output logic [AW-1:0]  ex_rd,
    output logic           ex_reg_write,
    output logic           ex_mem_read,
    output logic           ex_mem_write,
    output logic [DW-1:0]  ex_store_data,
    output logic [15:0]    bubble_count
);
    typedef struct packed {
        logic           valid;
        logic [OPW-1:0] aluop;
        logic [4:0]     shamt;
        logic [AW-1:0]  rs;
        logic [AW-1:0]  rt;
        logic [AW-1:0]  rd;
        logic [DW-1:0]  rs_data;
        logic [DW-1:0]  rt_data;
        logic [DW-1:0]  imm;
        logic           use_imm;
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
    } ex_regs_t;

    ex_regs_t ex, id_fields;
    logic     hazard;
    logic [DW-1:0] rs_fwd, rt_fwd;

    // Control bits are qualified by id_valid so an empty slot never writes.
    always_comb begin
        id_fields           = '0;
        id_fields.valid     = id_valid;
        id_fields.aluop     = id_aluop;
        id_fields.shamt     = id_shamt;
        id_fields.rs        = id_rs;
        id_fields.rt        = id_rt;
        id_fields.rd        = id_rd;
        id_fields.rs_data   = id_rs_data;
        id_fields.rt_data   = id_rt_data;
        id_fields.imm       = id_imm;
        id_fields.use_imm   = id_use_imm;
        id_fields.reg_write = id_reg_write & id_valid;
        id_fields.mem_read  = id_mem_read  & id_valid;
        id_fields.mem_write = id_mem_write & id_valid;
    end

    // A load in EX cannot forward in time for the instruction directly behind it.
    assign hazard = id_valid && ex.valid && ex.mem_read && (ex.rd != '0) &&
                    ((ex.rd == id_rs) || (id_uses_rt && ex.rd == id_rt));

    // Gated by rst_n so stall drops the instant reset asserts, even under hold.
    assign stall = rst_n & (hold | (hazard & ~flush));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex           <= '0;
            bubble_count <= '0;
        end else if (!hold) begin
            if (flush) begin
                ex <= '0;
            end else if (hazard) begin
                ex <= '0;
                if (bubble_count != 16'hFFFF)
                    bubble_count <= bubble_count + 16'd1;
            end else begin
                ex <= id_fields;
            end
        end
    end

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rs (
        .r(ex.rs), .v(ex.rs_data),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
        .q(rs_fwd)
    );

    fwd_mux #(.DW(DW), .AW(AW)) u_fwd_rt (
        .r(ex.rt), .v(ex.rt_data),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
        .q(rt_fwd)
    );

    assign ex_valid       = ex.valid;
    assign aluop_selector = ex.aluop;
    assign shamt          = ex.shamt;
    assign ex_rd          = ex.rd;
    assign ex_reg_write   = ex.reg_write;
    assign ex_mem_read    = ex.mem_read;
    assign ex_mem_write   = ex.mem_write;
    assign alu_in1        = rs_fwd;
    assign alu_in2        = ex.use_imm ? ex.imm : rt_fwd;
    assign ex_store_data  = rt_fwd;
endmodule

// File: tb/tb_id_ex_issue.sv
// Randomized + directed bench for id_ex_issue against a behavioural pipeline model.
module tb_id_ex_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_use_imm, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
    logic [3:0]  id_aluop;
    logic [4:0]  id_shamt, id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        hold, flush;
    logic        ex_mem_reg_write, mem_wb_reg_write;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic [31:0] ex_mem_result, mem_wb_result;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [3:0]  aluop_selector;
    logic [4:0]  shamt, ex_rd;
    logic [31:0] alu_in1, alu_in2, ex_store_data;
    logic [15:0] bubble_count;

    int n_chk = 0;
    int n_err = 0;

    // Model of what the EX stage should currently hold.
    logic        m_valid, m_use_imm, m_rw, m_mr, m_mw;
    logic [3:0]  m_aluop;
    logic [4:0]  m_shamt, m_rs, m_rt, m_rd;
    logic [31:0] m_rs_d, m_rt_d, m_imm;
    int          m_bc;

    always #5 clk = ~clk;

    id_ex_issue dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_aluop(id_aluop), .id_shamt(id_shamt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_uses_rt(id_uses_rt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .hold(hold), .flush(flush),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
        .stall(stall), .ex_valid(ex_valid), .aluop_selector(aluop_selector), .shamt(shamt),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data), .bubble_count(bubble_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
        if (r == 0) return v;
        if (ex_mem_reg_write && ex_mem_rd == r) return ex_mem_result;
        if (mem_wb_reg_write && mem_wb_rd == r) return mem_wb_result;
        return v;
    endfunction

    task automatic model_clear(input logic clr_bc);
        {m_valid, m_use_imm, m_rw, m_mr, m_mw} = '0;
        m_aluop = 0; m_shamt = 0; m_rs = 0; m_rt = 0; m_rd = 0;
        m_rs_d = 0; m_rt_d = 0; m_imm = 0;
        if (clr_bc) m_bc = 0;
    endtask

    task automatic set_idle();
        id_valid = 0; id_use_imm = 0; id_uses_rt = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        id_aluop = 0; id_shamt = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        hold = 0; flush = 0;
        ex_mem_reg_write = 0; ex_mem_rd = 0; ex_mem_result = 0;
        mem_wb_reg_write = 0; mem_wb_rd = 0; mem_wb_result = 0;
    endtask

    task automatic set_random();
        id_valid     = ($urandom_range(0, 7) != 0);
        id_aluop     = 4'($urandom_range(0, 9));
        id_shamt     = 5'($urandom);
        id_rs        = 5'($urandom_range(0, 7));
        id_rt        = 5'($urandom_range(0, 7));
        id_rd        = 5'($urandom_range(0, 7));
        id_rs_data   = $urandom;
        id_rt_data   = $urandom;
        id_imm       = $urandom;
        id_use_imm   = 1'($urandom);
        id_uses_rt   = 1'($urandom);
        id_mem_read  = id_valid && ($urandom_range(0, 2) == 0);
        id_mem_write = id_valid && !id_mem_read && ($urandom_range(0, 3) == 0);
        id_reg_write = id_valid && (id_mem_read || 1'($urandom));
        hold         = ($urandom_range(0, 5) == 0);
        flush        = ($urandom_range(0, 7) == 0);
        ex_mem_reg_write = 1'($urandom);
        ex_mem_rd        = 5'($urandom_range(0, 7));
        ex_mem_result    = $urandom;
        mem_wb_reg_write = 1'($urandom);
        mem_wb_rd        = 5'($urandom_range(0, 7));
        mem_wb_result    = $urandom;
    endtask

    // Called at a negedge with inputs applied: check outputs, clock once, advance model.
    task automatic step();
        logic hz;
        #1;
        hz = id_valid && m_valid && m_mr && m_rd != 0 &&
             (m_rd == id_rs || (id_uses_rt && m_rd == id_rt));
        chk("stall", {31'b0, stall}, {31'b0, hold | (hz & ~flush)});
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
        chk("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m_rw});
        chk("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m_mr});
        chk("ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m_mw});
        chk("aluop", {28'b0, aluop_selector}, {28'b0, m_aluop});
        chk("bubble_count", {16'b0, bubble_count}, 32'(m_bc));
        if (m_valid) begin
            chk("shamt", {27'b0, shamt}, {27'b0, m_shamt});
            chk("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
            chk("alu_in1", alu_in1, fwd(m_rs, m_rs_d));
            chk("alu_in2", alu_in2, m_use_imm ? m_imm : fwd(m_rt, m_rt_d));
            chk("store_data", ex_store_data, fwd(m_rt, m_rt_d));
        end
        @(posedge clk);
        if (!hold) begin
            if (flush || hz) begin
                model_clear(1'b0);
                if (!flush && m_bc < 65535) m_bc++;
            end else begin
                m_valid = id_valid; m_aluop = id_aluop; m_shamt = id_shamt;
                m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
                m_rs_d = id_rs_data; m_rt_d = id_rt_data; m_imm = id_imm;
                m_use_imm = id_use_imm;
                m_rw = id_reg_write; m_mr = id_mem_read; m_mw = id_mem_write;
            end
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid = 1; id_aluop = op; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd;
    endtask

    initial begin
        int bc0;
        set_idle();
        model_clear(1'b1);
        rst_n = 0;
        #1;
        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_bc", {16'b0, bubble_count}, 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Plain issue: add r3 = r1 + r2.
        issue(4'b0000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        id_uses_rt = 1; id_reg_write = 1;
        step();
        #1;
        chk("plain_aluop", {28'b0, aluop_selector}, 32'd0);
        chk("plain_in1", alu_in1, 32'd5);
        chk("plain_in2", alu_in2, 32'd7);
        chk("plain_rd", {27'b0, ex_rd}, 32'd3);
        chk("plain_valid", {31'b0, ex_valid}, 32'd1);

        // Forwarding priority on rs=3.
        set_idle();
        issue(4'b0001, 5'd3, 5'd0, 5'd6, 32'h55, 32'h0);
        step();
        ex_mem_reg_write = 1; ex_mem_rd = 3; ex_mem_result = 32'h10;
        mem_wb_reg_write = 1; mem_wb_rd = 3; mem_wb_result = 32'h20;
        #1 chk("fwd_exmem_wins", alu_in1, 32'h10);
        ex_mem_reg_write = 0;
        #1 chk("fwd_memwb", alu_in1, 32'h20);
        set_idle();
        issue(4'b0001, 5'd0, 5'd0, 5'd6, 32'h77, 32'h0);
        step();
        ex_mem_reg_write = 1; ex_mem_rd = 0; ex_mem_result = 32'h10;
        mem_wb_reg_write = 1; mem_wb_rd = 0; mem_wb_result = 32'h20;
        #1 chk("fwd_r0", alu_in1, 32'h77);

        // Load-use: lw r4 then add using r4.
        set_idle();
        issue(4'b0000, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0);
        id_mem_read = 1; id_reg_write = 1;
        step();
        set_idle();
        issue(4'b0000, 5'd4, 5'd1, 5'd5, 32'h1, 32'h2);
        id_reg_write = 1; id_uses_rt = 1;
        bc0 = m_bc;
        #1 chk("lu_stall", {31'b0, stall}, 32'd1);
        step();
        #1;
        chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
        chk("lu_bubble_rw", {31'b0, ex_reg_write}, 32'd0);
        chk("lu_bc", {16'b0, bubble_count}, 32'(bc0 + 1));
        chk("lu_stall_clear", {31'b0, stall}, 32'd0);
        ex_mem_reg_write = 1; ex_mem_rd = 4; ex_mem_result = 32'hAB;
        step();
        #1;
        chk("lu_issue_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu_fwd", alu_in1, 32'hAB);

        // Immediate operand with store.
        set_idle();
        issue(4'b0000, 5'd2, 5'd5, 5'd0, 32'h100, 32'd9);
        id_use_imm = 1; id_imm = 32'hFFFF_FFFC; id_mem_write = 1; id_uses_rt = 1;
        step();
        #1;
        chk("imm_in2", alu_in2, 32'hFFFF_FFFC);
        chk("store_data_rt", ex_store_data, 32'd9);

        // Hold for two cycles with a pending hazard, then flush.
        set_idle();
        issue(4'b0000, 5'd0, 5'd0, 5'd4, 32'h0, 32'h0);
        id_mem_read = 1; id_reg_write = 1;
        step();
        set_idle();
        issue(4'b0000, 5'd4, 5'd0, 5'd7, 32'h3, 32'h0);
        hold = 1;
        bc0 = m_bc;
        step();
        step();
        #1;
        chk("hold_stall", {31'b0, stall}, 32'd1);
        chk("hold_rd", {27'b0, ex_rd}, 32'd4);
        chk("hold_mr", {31'b0, ex_mem_read}, 32'd1);
        hold = 0; flush = 1;
        #1 chk("flush_stall", {31'b0, stall}, 32'd0);
        step();
        #1;
        chk("flush_bubble", {31'b0, ex_valid}, 32'd0);
        chk("flush_bc", {16'b0, bubble_count}, 32'(bc0));

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_random();
            step();
        end

        // Asynchronous reset mid-cycle while stalled by hold.
        set_random();
        id_valid = 1; hold = 1;
        #2 rst_n = 0;
        #1;
        chk("arst_stall", {31'b0, stall}, 32'd0);
        chk("arst_valid", {31'b0, ex_valid}, 32'd0);
        chk("arst_rw", {31'b0, ex_reg_write}, 32'd0);
        chk("arst_aluop", {28'b0, aluop_selector}, 32'd0);
        chk("arst_in1", alu_in1, 32'd0);
        chk("arst_in2", alu_in2, 32'd0);
        chk("arst_bc", {16'b0, bubble_count}, 32'd0);
        model_clear(1'b1);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 100; i++) begin
            set_random();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
